// File: rtl/dsp_mac_pipe.sv
// rtl/dsp_mac_pipe.sv - streaming signed MAC with pre-adder, C post-add and grouped accumulation (DSPMAC_SAT_EN enables saturation)
module dsp_mac_pipe #(
    parameter int AW      = 18,
    parameter int BW      = 18,
    parameter int PW      = 48,
    parameter int MPIPE   = 2,
    parameter int ACC_LEN = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic signed [AW-1:0] a,
    input  logic signed [BW-1:0] b,
    input  logic signed [BW-1:0] d,
    input  logic signed [PW-1:0] c,
    input  logic        [1:0]    mode,
    input  logic                 acc_en,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic        [PW-1:0] p,
    output logic                 ovf
);

    localparam int MW  = AW + BW + 1;
    localparam int PAW = BW + 1;
    localparam int CW  = (ACC_LEN > 1) ? $clog2(ACC_LEN) : 1;

    typedef enum logic {
        IDLE  = 1'b0,
        GROUP = 1'b1
    } acc_state_t;

    // One global enable: the whole pipe freezes while a result waits downstream.
    logic ce;
    assign ce       = !out_valid || out_ready;
    assign in_ready = ce;

    logic                 i_vld;
    logic signed [AW-1:0] i_a;
    logic signed [BW-1:0] i_b;
    logic signed [BW-1:0] i_d;
    logic signed [PW-1:0] i_c;
    logic        [1:0]    i_mode;
    logic                 i_acc;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            i_vld  <= 1'b0;
            i_a    <= '0;
            i_b    <= '0;
            i_d    <= '0;
            i_c    <= '0;
            i_mode <= '0;
            i_acc  <= 1'b0;
        end else if (ce) begin
            i_vld <= in_valid;
            if (in_valid) begin
                i_a    <= a;
                i_b    <= b;
                i_d    <= d;
                i_c    <= c;
                i_mode <= mode;
                i_acc  <= acc_en;
            end
        end
    end

    logic signed [PAW-1:0] pre;
    logic signed [MW-1:0]  prod0;
    logic signed [PW-1:0]  csel0;

    always_comb begin
        case (i_mode)
            2'b01:   pre = PAW'(i_d) + PAW'(i_b);
            2'b10:   pre = PAW'(i_d) - PAW'(i_b);
            default: pre = PAW'(i_b);
        endcase
        prod0 = MW'(i_a) * MW'(pre);
        csel0 = (i_mode == 2'b11) ? i_c : '0;
    end

    logic                m_vld  [MPIPE];
    logic signed [MW-1:0] m_prod [MPIPE];
    logic signed [PW-1:0] m_c    [MPIPE];
    logic                m_acc  [MPIPE];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < MPIPE; i++) begin
                m_vld[i]  <= 1'b0;
                m_prod[i] <= '0;
                m_c[i]    <= '0;
                m_acc[i]  <= 1'b0;
            end
        end else if (ce) begin
            m_vld[0]  <= i_vld;
            m_prod[0] <= prod0;
            m_c[0]    <= csel0;
            m_acc[0]  <= i_acc;
            for (int i = 1; i < MPIPE; i++) begin
                m_vld[i]  <= m_vld[i-1];
                m_prod[i] <= m_prod[i-1];
                m_c[i]    <= m_c[i-1];
                m_acc[i]  <= m_acc[i-1];
            end
        end
    end

    // Returns {overflow, sum}; the overflow bit is only ever set when saturation is built in.
    function automatic logic [PW:0] add_pw(input logic signed [PW-1:0] x, input logic signed [PW-1:0] y);
        logic signed [PW-1:0] s;
        logic                 ov;
        s = x + y;
`ifdef DSPMAC_SAT_EN
        ov = (x[PW-1] == y[PW-1]) && (s[PW-1] != x[PW-1]);
        if (ov) s = x[PW-1] ? {1'b1, {(PW-1){1'b0}}} : {1'b0, {(PW-1){1'b1}}};
`else
        ov = 1'b0;
`endif
        return {ov, s};
    endfunction

    acc_state_t           state, state_nxt;
    logic [CW-1:0]        cnt, cnt_nxt;
    logic signed [PW-1:0] acc, acc_nxt;
    logic                 grp_ovf, grp_ovf_nxt;
    logic                 ovf_q;

    logic                 s_vld;
    logic                 s_acc;
    logic [PW:0]          t_res;
    logic [PW:0]          a_res;
    logic signed [PW-1:0] term;
    logic signed [PW-1:0] sum;
    logic                 emit;
    logic signed [PW-1:0] res;
    logic                 res_ov;

    assign s_vld = m_vld[MPIPE-1];
    assign s_acc = m_acc[MPIPE-1];
    assign t_res = add_pw(PW'(m_prod[MPIPE-1]), m_c[MPIPE-1]);
    assign term  = t_res[PW-1:0];
    assign a_res = add_pw(acc, term);
    assign sum   = a_res[PW-1:0];

    always_comb begin
        state_nxt   = state;
        cnt_nxt     = cnt;
        acc_nxt     = acc;
        grp_ovf_nxt = grp_ovf;
        emit        = 1'b0;
        res         = term;
        res_ov      = t_res[PW];
        if (ce && s_vld) begin
            case (state)
                IDLE: begin
                    if (!s_acc || ACC_LEN == 1) begin
                        emit = 1'b1;
                    end else begin
                        state_nxt   = GROUP;
                        cnt_nxt     = CW'(1);
                        acc_nxt     = term;
                        grp_ovf_nxt = t_res[PW];
                    end
                end
                GROUP: begin
                    res    = sum;
                    res_ov = grp_ovf | t_res[PW] | a_res[PW];
                    // A non-group beat closes the group early, folding itself into the sum.
                    if (!s_acc || cnt == CW'(ACC_LEN - 1)) begin
                        emit        = 1'b1;
                        state_nxt   = IDLE;
                        cnt_nxt     = '0;
                        grp_ovf_nxt = 1'b0;
                    end else begin
                        acc_nxt     = sum;
                        cnt_nxt     = cnt + CW'(1);
                        grp_ovf_nxt = res_ov;
                    end
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= '0;
            acc       <= '0;
            grp_ovf   <= 1'b0;
            out_valid <= 1'b0;
            p         <= '0;
            ovf_q     <= 1'b0;
        end else begin
            state   <= state_nxt;
            cnt     <= cnt_nxt;
            acc     <= acc_nxt;
            grp_ovf <= grp_ovf_nxt;
            if (ce) out_valid <= emit;
            if (emit) begin
                p     <= res;
                ovf_q <= res_ov;
            end
        end
    end

    assign ovf = ovf_q;

endmodule

// File: tb/tb_dsp_mac_pipe.sv
// tb/tb_dsp_mac_pipe.sv - scoreboard bench for dsp_mac_pipe (honours DSPMAC_SAT_EN)
module tb_dsp_mac_pipe;

    localparam int AW      = 18;
    localparam int BW      = 18;
    localparam int PW      = 48;
    localparam int MPIPE   = 2;
    localparam int ACC_LEN = 4;

    logic                 clk = 1'b0;
    logic                 rst;
    logic                 in_valid;
    logic                 in_ready;
    logic signed [AW-1:0] a;
    logic signed [BW-1:0] b;
    logic signed [BW-1:0] d;
    logic signed [PW-1:0] c;
    logic        [1:0]    mode;
    logic                 acc_en;
    logic                 out_valid;
    logic                 out_ready;
    logic        [PW-1:0] p;
    logic                 ovf;

    dsp_mac_pipe #(.AW(AW), .BW(BW), .PW(PW), .MPIPE(MPIPE), .ACC_LEN(ACC_LEN)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .d(d), .c(c), .mode(mode), .acc_en(acc_en),
        .out_valid(out_valid), .out_ready(out_ready), .p(p), .ovf(ovf)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;
    int cyc   = 0;
    bit rdy_random = 0;
    bit rdy_force  = 1;

    logic [PW-1:0] exp_p_q[$];
    bit            exp_o_q[$];

    bit     in_grp;
    int     g_n;
    longint g_acc;
    bit     g_sat;

    task automatic check(input string nm, input longint got, input longint exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, got, exp);
        end
    endtask

    function automatic longint fit(input longint v, output bit sat);
        longint        mx;
        longint        mn;
        logic [PW-1:0] t;
        mx = (longint'(1) <<< (PW-1)) - 1;
        mn = -mx - 1;
        t  = v[PW-1:0];
`ifdef DSPMAC_SAT_EN
        sat = (v > mx) || (v < mn);
        if (v > mx) return mx;
        if (v < mn) return mn;
        return v;
`else
        sat = 1'b0;
        return longint'($signed(t));
`endif
    endfunction

    task automatic push(input longint v, input bit o, input bit use_ov, input longint op, input bit of);
        exp_p_q.push_back(use_ov ? PW'(op) : PW'(v));
        exp_o_q.push_back(use_ov ? of : o);
    endtask

    // Reference: products accumulate in groups of up to ACC_LEN beats; a non-group beat ends a group.
    task automatic model_beat(input bit use_ov, input longint op, input bit of);
        longint pre, term, s;
        bit     ts, ss;
        case (mode)
            2'd1:    pre = longint'(d) + longint'(b);
            2'd2:    pre = longint'(d) - longint'(b);
            default: pre = longint'(b);
        endcase
        term = fit(longint'(a) * pre + ((mode == 2'd3) ? longint'(c) : 0), ts);
        if (!in_grp) begin
            if (!acc_en || ACC_LEN == 1) push(term, ts, use_ov, op, of);
            else begin
                in_grp = 1; g_acc = term; g_n = 1; g_sat = ts;
            end
        end else begin
            s = fit(g_acc + term, ss);
            if (!acc_en || g_n + 1 == ACC_LEN) begin
                push(s, g_sat | ts | ss, use_ov, op, of);
                in_grp = 0;
            end else begin
                g_acc = s; g_n++; g_sat = g_sat | ts | ss;
            end
        end
    endtask

    task automatic drive(input int ta, input int tb, input int td, input longint tc, input int tm, input bit te,
                         input bit use_ov = 0, input longint op = 0, input bit of = 0);
        bit accepted;
        int n;
        in_valid = 1; a = AW'(ta); b = BW'(tb); d = BW'(td); c = PW'(tc); mode = 2'(tm); acc_en = te;
        accepted = 0;
        n = 0;
        while (!accepted) begin
            @(negedge clk);
            if (in_ready) begin
                accepted = 1;
                model_beat(use_ov, op, of);
            end
            @(posedge clk); #1;
            if (!accepted && ++n > 100) begin
                n_vec++; n_err++;
                $display("FAIL accept_timeout: beat not accepted in 100 cycles");
                accepted = 1;
            end
        end
        in_valid = 0;
    endtask

    task automatic latency_from_accept(output int n);
        n = 1;
        while (!out_valid && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
    endtask

    initial forever begin
        @(posedge clk); cyc++;
    end

    initial begin
        out_ready = 1;
        forever begin
            @(posedge clk); #1;
            out_ready = rdy_random ? ($urandom_range(0, 3) != 0) : rdy_force;
        end
    end

    initial begin : monitor
        logic [PW-1:0] ep;
        logic [PW-1:0] held_p;
        bit            eo;
        bit            held_vld;
        held_vld = 0;
        held_p   = '0;
        forever begin
            @(negedge clk);
            if (rst) begin
                held_vld = 0;
            end else if (out_valid && out_ready) begin
                if (exp_p_q.size() == 0) begin
                    n_vec++; n_err++;
                    $display("FAIL unexpected_out: got p=%0h with no result expected", p);
                end else begin
                    ep = exp_p_q.pop_front();
                    eo = exp_o_q.pop_front();
                    check("p", p, ep);
                    check("ovf", ovf, eo);
                end
                held_vld = 0;
            end else if (out_valid) begin
                if (held_vld) check("p_hold", p, held_p);
                held_vld = 1;
                held_p   = p;
            end else begin
                held_vld = 0;
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        int     lat;
        int     c0;
        int     w;
        longint big;
        rst = 1; in_valid = 0; a = '0; b = '0; d = '0; c = '0; mode = '0; acc_en = 0;
        in_grp = 0; g_n = 0; g_acc = 0; g_sat = 0;
        repeat (2) @(posedge clk);
        #1 rst = 0;
        check("rst_out_valid", out_valid, 0);
        check("rst_p", p, 0);
        check("rst_ovf", ovf, 0);
        check("rst_in_ready", in_ready, 1);
        check("rst_cnt", dut.cnt, 0);

        drive(3, -5, 0, 0, 0, 0, 1, -15, 0);
        latency_from_accept(lat);
        check("latency_single", lat, MPIPE + 2);

        c0 = cyc;
        for (int i = 0; i < 8; i++) drive(i - 4, 7 + i, 0, 0, 0, 0);
        check("throughput_cycles", cyc - c0, 8);

        drive(-2, 4, 10, 0, 1, 0, 1, -28, 0);
        drive(-2, 4, 10, 0, 2, 0, 1, -12, 0);
        drive(7, 6, 0, 100, 3, 0, 1, 142, 0);

        drive(1, 2, 0, 0, 0, 1);
        drive(2, 2, 0, 0, 0, 1);
        drive(3, 2, 0, 0, 0, 1);
        drive(4, 2, 0, 0, 0, 1, 1, 20, 0);
        latency_from_accept(lat);
        check("latency_group", lat, MPIPE + 2);

        drive(1, 2, 0, 0, 0, 1);
        drive(2, 2, 0, 0, 0, 1);
        drive(3, 2, 0, 0, 0, 0, 1, 12, 0);
        drive(4, 2, 0, 0, 0, 1);
        drive(1, 2, 0, 0, 0, 1);
        drive(1, 2, 0, 0, 0, 1);
        drive(1, 2, 0, 0, 0, 1, 1, 14, 0);

        rdy_force = 0;
        fork
            begin
                for (int i = 0; i < 6; i++) drive(i + 1, 3, 0, 0, 0, 0);
            end
            begin
                w = 0;
                while (!out_valid && w < 50) begin
                    @(negedge clk); w++;
                end
                for (int k = 0; k < 5; k++) begin
                    @(negedge clk);
                    check("stall_in_ready", in_ready, 0);
                end
                rdy_force = 1;
            end
        join

        big = (longint'(1) <<< (PW-1)) - 1;
`ifdef DSPMAC_SAT_EN
        drive(1, 1, 0, big, 3, 0, 1, big, 1);
`else
        drive(1, 1, 0, big, 3, 0, 1, -big - 1, 0);
`endif

        drive(5, 5, 0, 0, 0, 0);
        drive(1, 1, 0, 0, 0, 1);
        drive(2, 1, 0, 0, 0, 1);
        @(posedge clk); #1;
        check("pre_rst_valid", out_valid, 1);
        check("pre_rst_p", p, 25);
        #2 rst = 1;
        #1;
        check("midrst_out_valid", out_valid, 0);
        check("midrst_p", p, 0);
        check("midrst_cnt", dut.cnt, 0);
        exp_p_q.delete();
        exp_o_q.delete();
        in_grp = 0; g_n = 0; g_acc = 0; g_sat = 0;
        @(posedge clk); #1 rst = 0;
        drive(1, 3, 0, 0, 0, 1);
        drive(2, 3, 0, 0, 0, 1);
        drive(3, 3, 0, 0, 0, 1);
        drive(4, 3, 0, 0, 0, 1, 1, 30, 0);

        rdy_random = 1;
        for (int i = 0; i < 300; i++) begin
            drive(int'($urandom), int'($urandom), int'($urandom),
                  longint'({$urandom, $urandom}), int'($urandom_range(0, 3)),
                  $urandom_range(0, 9) < 7);
            repeat ($urandom_range(0, 1)) begin
                @(posedge clk); #1;
            end
        end
        rdy_random = 0;
        rdy_force  = 1;

        w = 0;
        while (exp_p_q.size() != 0 && w < 200) begin
            @(posedge clk); #1; w++;
        end
        check("drain_empty", exp_p_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/dsp_mac_pipe.md
# dsp_mac_pipe

Parametrised, streaming successor to the DSP48A1 slice model. Multiplies signed operands with an optional pre-adder/pre-subtractor and C post-add, and can accumulate a programmable number of products into one result. Adds what the fixed slice lacks: generic widths, configurable multiplier pipeline depth, valid/ready flow control with full-pipeline stall, grouped accumulation, and optional saturation. It sits between sample sources and downstream filter/accumulator logic in the DSP datapath.

## Interface
- `AW`, 18: A operand width, signed.
- `BW`, 18: B and D operand width, signed.
- `PW`, 48: C and P width, signed; must satisfy PW ≥ AW+BW+1.
- `MPIPE`, 2: multiplier pipeline stages, 1..4.
- `ACC_LEN`, 16: products per accumulation group, ≥ 1.

Ports:
- `clk`  in  1  single clock, rising edge.
- `rst`  in  1  asynchronous, active-high reset for all state.
- `in_valid`  in  1  input beat present.
- `in_ready`  out  1  input beat accepted when `in_valid && in_ready`.
- `a`  in  AW  multiplier operand.
- `b`  in  BW  pre-adder operand 2 / direct multiplicand.
- `d`  in  BW  pre-adder operand 1.
- `c`  in  PW  post-add operand.
- `mode`  in  2  00 A·B; 01 A·(D+B); 10 A·(D−B); 11 A·B+C.
- `acc_en`  in  1  beat belongs to an accumulation group.
- `out_valid`  out  1  result `p` valid.
- `out_ready`  in  1  downstream accepts result.
- `p`  out  PW  result.
- `ovf`  out  1  overflow flag, qualified by `out_valid`.

## Operation
- All arithmetic is signed two's complement.
- The pre-adder result is BW+1 bits and does not truncate.
- The product is AW+BW+1 bits, sign-extended to PW.
- `mode`, `acc_en` and `c` travel with their beat through the pipe; `c` is added at the accumulate stage.
- Pipeline: input register → MPIPE multiplier stages → accumulate/P register. Each stage carries a valid bit.
- Global enable `ce = !out_valid || out_ready`; `in_ready = ce`. When `ce` = 0 every stage holds.
- Accumulate FSM, with counter `cnt` (0..ACC_LEN−1) and register `acc`:
  - IDLE (`cnt` = 0): a beat with `acc_en` = 0 gives result = term, emitted directly. A beat with `acc_en` = 1 sets acc = term, moves to GROUP, `cnt` = 1. If ACC_LEN = 1, it emits instead.
  - GROUP: a beat with `acc_en` = 1 sets acc += term and `cnt`++. When `cnt` reaches ACC_LEN−1, the sum is emitted and the FSM returns to IDLE.
  - GROUP, beat with `acc_en` = 0: terminates the group early. acc + term is emitted; return to IDLE.
  - Only emitted results raise `out_valid`; intermediate group beats produce no output.
- Overflow detection is on each add into PW bits (sign-based).
- Reset mid-group discards the partial sum; the FSM returns to IDLE.

## Timing
- Reset values: `p` = 0, `out_valid` = 0, `ovf` = 0, `cnt` = 0, all stage valids 0.
- `in_ready` = 1 after reset.
- Latency with no stall: MPIPE+2 cycles from acceptance to `out_valid`. Default is 4.
- A group's result appears MPIPE+2 cycles after its last beat is accepted.
- Throughput is one beat per cycle while `out_ready` = 1.
- `p`/`ovf` hold stable while `out_valid && !out_ready`.
- A result may be consumed and a new one loaded in the same cycle.
- Bubbles (`in_valid` = 0) do not advance `cnt`.

## Configuration
- `DSPMAC_SAT_EN` defined:
  - Every add saturates to [−2^(PW−1), 2^(PW−1)−1].
  - `ovf` = 1 on an emitted result if any add in its group saturated.
- Undefined:
  - Adds wrap modulo 2^PW.
  - `ovf` is tied to 0.

## Test plan
- Defaults, `mode` = 00, a=3, b=−5, `out_ready` = 1 → `p` = −15, `out_valid` exactly 4 cycles after acceptance. Back-to-back beats give one result per cycle.
- a=−2, d=10, b=4: `mode` = 01 → `p` = −28; `mode` = 10 → `p` = −12. `mode` = 11 with a=7, b=6, c=100 → `p` = 142.
- ACC_LEN = 4, `acc_en` = 1, `mode` = 00, a=1,2,3,4, b=2 → single result `p` = 20, 4 cycles after the 4th beat; no `out_valid` for the first three beats. Repeating the sequence with the 3rd beat `acc_en` = 0 → `p` = 12 early, then the next group starts clean.
- Hold `out_ready` = 0 for 5 cycles while results are pending → `in_ready` = 0, `p` stable, no beat lost or duplicated after release.
- `mode` = 11, c = 2^47−1, a=1, b=1 → with `DSPMAC_SAT_EN`: `p` = 2^47−1, `ovf` = 1. Without it: `p` = −2^47, `ovf` = 0.
- Assert `rst` after 2 beats of a group (asynchronous, mid-cycle) → `out_valid`, `p`, `cnt` are 0 immediately. A fresh 4-beat group afterwards gives the correct sum with no residue.
